rx_acl_pingpong_buf: RTL and testbench
======================================

RX_ACL_PINGPONG_BUF -- requirements
Module: rx_acl_pingpong_buf

Interface
REQ-001 Parameter: DW, 32, SRAM data width in bits.
REQ-002 Parameter: AW, 8, SRAM word-address width; bank depth is 2^AW words.
REQ-003 Parameter: NBANK, 2, number of payload banks; legal range 2..4.
REQ-004 Port: clk_6M  in  1  clock; rstz  in  1  reset, asynchronous, active-low.
REQ-005 Port: lnctrl_cs  in  1  link-controller SRAM select.
REQ-006 Port: lnctrl_we  in  1  link-controller write enable.
REQ-007 Port: lnctrl_addr  in  AW  write word address.
REQ-008 Port: lnctrl_din  in  DW  write data.
REQ-009 Port: lnctrl_wr_endp  in  1  one-cycle pulse marking end of a received payload.
REQ-010 Port: lnctrl_len  in  AW+1  payload length in words, sampled on lnctrl_wr_endp.
REQ-011 Port: lnctrl_crc_ok  in  1  payload CRC status, sampled on lnctrl_wr_endp.
REQ-012 Port: bsm_cs  in  1  reader SRAM select; bsm_addr  in  AW  read word address.
REQ-013 Port: bsm_read_endp  in  1  one-cycle pulse: reader has finished the current bank.
REQ-014 Port: ovr_clr  in  1  clears the overrun flag.
REQ-015 Port: bsm_dout  out  DW  read data; bsm_rdy  out  1  a committed bank is available.
REQ-016 Port: bsm_len  out  AW+1  length of the bank at the read pointer.
REQ-017 Port: rx_flow_go  out  1  free bank exists (ACL flow GO=1, STOP=0).
REQ-018 Port: overrun  out  1  sticky overrun flag; occ  out  $clog2(NBANK+1)  committed-bank count.

Function
REQ-019 Banks form a circular queue with registers wr_ptr, rd_ptr (0..NBANK-1) and occ (0..NBANK).
REQ-020 A write occurs when lnctrl_cs & lnctrl_we & (occ<NBANK); it targets bank wr_ptr at lnctrl_addr.
REQ-021 A write attempt with occ==NBANK is dropped and sets overrun on the next edge.
REQ-022 A commit occurs on lnctrl_wr_endp with occ<NBANK: len[wr_ptr] is stored, wr_ptr advances (NBANK-1 wraps to 0), and occ increments.
REQ-023 lnctrl_wr_endp with occ==NBANK is ignored and sets overrun.
REQ-024 A read occurs when bsm_cs & (occ>0); it targets bank rd_ptr; bsm_dout is valid one cycle after bsm_cs; bsm_dout holds its last value otherwise.
REQ-025 bsm_read_endp with occ>0 releases bank rd_ptr: rd_ptr advances with wrap and occ decrements; with occ==0 it is ignored.
REQ-026 Simultaneous commit and release: both pointers advance and occ is unchanged.
REQ-027 lnctrl_len > 2^AW is stored clamped to 2^AW.
REQ-028 bsm_rdy=(occ!=0), rx_flow_go=(occ!=NBANK), bsm_len=len[rd_ptr]; all are decoded from registers only.
REQ-029 Reader and writer may be active in the same cycle on different banks, with no arbitration stall.
REQ-030 overrun has priority set over ovr_clr when both occur in the same cycle.

Reset
REQ-031 On rstz low: wr_ptr=0, rd_ptr=0, occ=0, all len=0, overrun=0, bsm_dout=0; so bsm_rdy=0 and rx_flow_go=1.
REQ-032 Reset in mid-payload discards all bank contents logically; SRAM data is not cleared.

Configuration
REQ-033 Macro RXACL_CRC_DROP_EN: when defined, lnctrl_wr_endp with lnctrl_crc_ok=0 does not commit (wr_ptr, occ and len are unchanged), and the bank is rewritten by the next payload.
REQ-034 When RXACL_CRC_DROP_EN is undefined, lnctrl_crc_ok is ignored and every accepted wr_endp commits.

Structure
REQ-035 Shared package rxacl_pkg holds the default DW/AW/NBANK constants, the ptr_t and len_t typedefs, and the function clog2.
REQ-036 One sub-module, sram_1p_param (DW x 2^AW, single port, synchronous read), is instantiated NBANK times with a generate loop.

Verification
REQ-037 Write 4 words to bank 0, then wr_endp with len=4 -> occ=1, bsm_rdy=1, bsm_len=4; a read of addr 2 returns the written data 1 cycle later.
REQ-038 NBANK=2: commit two payloads, then write a third -> rx_flow_go=0, the write is dropped, overrun=1; after ovr_clr, overrun=0.
REQ-039 occ=1 with commit and bsm_read_endp in the same cycle -> occ stays 1, both pointers advance, bsm_len reflects the new bank.
REQ-040 NBANK=4: run 9 commit/release cycles -> pointers wrap 3->0 twice, and data integrity holds per bank.
REQ-041 With RXACL_CRC_DROP_EN defined, wr_endp with crc_ok=0 -> occ unchanged and bsm_rdy stays 0; without the macro -> occ=1.
REQ-042 Assert rstz with occ=2 -> occ=0, bsm_rdy=0, rx_flow_go=1, overrun=0.

Source files
------------

// File: rtl/rx_acl_pingpong_buf_pkg.sv
// Shared constants, pointer/length types and clog2 for the RX ACL ping-pong payload buffer.
package rxacl_pkg;

  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 8;
  localparam int NBANK_DEF = 2;

  // Wide enough for the largest legal bank count (4).
  typedef logic [1:0]      ptr_t;
  typedef logic [AW_DEF:0] len_t;

  function automatic int clog2(input int x);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((1 << i) < x) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_acl_pingpong_buf_sram.sv
// Single-port DW x 2^AW SRAM with synchronous read; one instance per payload bank.
module sram_1p_param #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk_6M,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_6M) begin
    if (cs) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/rx_acl_pingpong_buf.sv
// RX ACL payload buffer: NBANK SRAM banks used as a circular queue between link controller and reader.
// Optional macro RXACL_CRC_DROP_EN: payloads ending with lnctrl_crc_ok=0 are not committed.
module rx_acl_pingpong_buf
  import rxacl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int NBANK = NBANK_DEF
) (
  input  logic                         clk_6M,
  input  logic                         rstz,
  input  logic                         lnctrl_cs,
  input  logic                         lnctrl_we,
  input  logic [AW-1:0]                lnctrl_addr,
  input  logic [DW-1:0]                lnctrl_din,
  input  logic                         lnctrl_wr_endp,
  input  logic [AW:0]                  lnctrl_len,
  input  logic                         lnctrl_crc_ok,
  input  logic                         bsm_cs,
  input  logic [AW-1:0]                bsm_addr,
  input  logic                         bsm_read_endp,
  input  logic                         ovr_clr,
  output logic [DW-1:0]                bsm_dout,
  output logic                         bsm_rdy,
  output logic [AW:0]                  bsm_len,
  output logic                         rx_flow_go,
  output logic                         overrun,
  output logic [clog2(NBANK+1)-1:0]    occ
);

  localparam int               OW      = clog2(NBANK+1);
  localparam logic [OW-1:0]    FULL    = OW'(NBANK);
  localparam ptr_t             LAST    = ptr_t'(NBANK-1);
  localparam logic [AW:0]      LEN_MAX = {1'b1, {AW{1'b0}}};

  ptr_t          wr_ptr, rd_ptr, rd_bank;
  logic [AW:0]   len_r [NBANK];
  logic [AW:0]   len_in;
  logic [DW-1:0] q [NBANK];
  logic [DW-1:0] q_sel, hold;
  logic          full, empty, wr_fire, rd_fire, commit, rel, ovr_set, rd_vld;

  assign full    = (occ == FULL);
  assign empty   = (occ == '0);
  assign wr_fire = lnctrl_cs & lnctrl_we & ~full;
  assign rd_fire = bsm_cs & ~empty;
  assign rel     = bsm_read_endp & ~empty;
  assign ovr_set = full & ((lnctrl_cs & lnctrl_we) | lnctrl_wr_endp);
  assign len_in  = (lnctrl_len > LEN_MAX) ? LEN_MAX : lnctrl_len;

`ifdef RXACL_CRC_DROP_EN
  assign commit = lnctrl_wr_endp & ~full & lnctrl_crc_ok;
`else
  logic unused_crc_ok;
  assign unused_crc_ok = lnctrl_crc_ok;
  assign commit        = lnctrl_wr_endp & ~full;
`endif

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      overrun <= 1'b0;
      for (int unsigned b = 0; b < NBANK; b++) len_r[b] <= '0;
    end else begin
      if (commit) begin
        for (int unsigned b = 0; b < NBANK; b++) begin
          if (wr_ptr == ptr_t'(b)) len_r[b] <= len_in;
        end
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rel) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (commit && !rel)      occ <= occ + 1'b1;
      else if (rel && !commit) occ <= occ - 1'b1;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  // Writer and reader never share a bank: wr_ptr==rd_ptr only when empty or full,
  // and in both cases one side is blocked, so a per-bank address mux suffices.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic          sel_w, sel_r;
    logic [AW-1:0] addr_b;
    assign sel_w  = wr_fire & (wr_ptr == ptr_t'(b));
    assign sel_r  = rd_fire & (rd_ptr == ptr_t'(b));
    assign addr_b = sel_w ? lnctrl_addr : bsm_addr;
    sram_1p_param #(.DW(DW), .AW(AW)) u_sram (
      .clk_6M (clk_6M),
      .cs     (sel_w | sel_r),
      .we     (sel_w),
      .addr   (addr_b),
      .din    (lnctrl_din),
      .dout   (q[b])
    );
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      rd_vld  <= 1'b0;
      rd_bank <= '0;
      hold    <= '0;
    end else begin
      rd_vld <= rd_fire;
      if (rd_fire) rd_bank <= rd_ptr;
      if (rd_vld)  hold    <= q_sel;
    end
  end

  always_comb begin
    q_sel   = '0;
    bsm_len = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (rd_bank == ptr_t'(b)) q_sel   = q[b];
      if (rd_ptr  == ptr_t'(b)) bsm_len = len_r[b];
    end
  end

  // Fresh SRAM data in the cycle after a read, the captured copy otherwise.
  assign bsm_dout   = rd_vld ? q_sel : hold;
  assign bsm_rdy    = ~empty;
  assign rx_flow_go = ~full;

endmodule

// File: tb/tb_rx_acl_pingpong_buf.sv
// Self-checking bench: NBANK=4 and NBANK=3 buffers share stimulus, each tracked by a queue-level model.
module tb_rx_acl_pingpong_buf;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  always #5 clk_6M = ~clk_6M;

  logic          lnctrl_cs, lnctrl_we, lnctrl_wr_endp, lnctrl_crc_ok;
  logic [AW-1:0] lnctrl_addr, bsm_addr;
  logic [DW-1:0] lnctrl_din;
  logic [AW:0]   lnctrl_len;
  logic          bsm_cs, bsm_read_endp, ovr_clr;

  logic [DW-1:0] dout4, dout3;
  logic [AW:0]   len4, len3;
  logic          rdy4, rdy3, go4, go3, ovr4, ovr3;
  logic [2:0]    occ4;
  logic [1:0]    occ3;

  rx_acl_pingpong_buf #(.DW(DW), .AW(AW), .NBANK(4)) u_dut4 (
    .clk_6M(clk_6M), .rstz(rstz), .lnctrl_cs(lnctrl_cs), .lnctrl_we(lnctrl_we),
    .lnctrl_addr(lnctrl_addr), .lnctrl_din(lnctrl_din), .lnctrl_wr_endp(lnctrl_wr_endp),
    .lnctrl_len(lnctrl_len), .lnctrl_crc_ok(lnctrl_crc_ok), .bsm_cs(bsm_cs),
    .bsm_addr(bsm_addr), .bsm_read_endp(bsm_read_endp), .ovr_clr(ovr_clr),
    .bsm_dout(dout4), .bsm_rdy(rdy4), .bsm_len(len4), .rx_flow_go(go4),
    .overrun(ovr4), .occ(occ4)
  );

  rx_acl_pingpong_buf #(.DW(DW), .AW(AW), .NBANK(3)) u_dut3 (
    .clk_6M(clk_6M), .rstz(rstz), .lnctrl_cs(lnctrl_cs), .lnctrl_we(lnctrl_we),
    .lnctrl_addr(lnctrl_addr), .lnctrl_din(lnctrl_din), .lnctrl_wr_endp(lnctrl_wr_endp),
    .lnctrl_len(lnctrl_len), .lnctrl_crc_ok(lnctrl_crc_ok), .bsm_cs(bsm_cs),
    .bsm_addr(bsm_addr), .bsm_read_endp(bsm_read_endp), .ovr_clr(ovr_clr),
    .bsm_dout(dout3), .bsm_rdy(rdy3), .bsm_len(len3), .rx_flow_go(go3),
    .overrun(ovr3), .occ(occ3)
  );

  int nb [2] = '{4, 3};
  int m_wr [2], m_rd [2], m_occ [2];
  int m_len [2][4];
  bit m_ovr [2];
  logic [DW-1:0] mem [2][4][DEPTH];
  bit memv [2][4][DEPTH];
  logic [DW-1:0] m_dout [2];
  bit m_dknown [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wr[k] = 0; m_rd[k] = 0; m_occ[k] = 0; m_ovr[k] = 1'b0;
      m_dout[k] = '0; m_dknown[k] = 1'b1;
      for (int b = 0; b < 4; b++) m_len[k][b] = 0;
    end
  endtask

  task automatic model_step();
    bit full, commit, rel;
    for (int k = 0; k < 2; k++) begin
      full   = (m_occ[k] == nb[k]);
      commit = lnctrl_wr_endp && !full;
`ifdef RXACL_CRC_DROP_EN
      commit = commit && lnctrl_crc_ok;
`endif
      rel = bsm_read_endp && (m_occ[k] > 0);
      if (bsm_cs && m_occ[k] > 0) begin
        m_dout[k]   = mem[k][m_rd[k]][bsm_addr];
        m_dknown[k] = memv[k][m_rd[k]][bsm_addr];
      end
      if (lnctrl_cs && lnctrl_we && !full) begin
        mem[k][m_wr[k]][lnctrl_addr]  = lnctrl_din;
        memv[k][m_wr[k]][lnctrl_addr] = 1'b1;
      end
      if (full && ((lnctrl_cs && lnctrl_we) || lnctrl_wr_endp)) m_ovr[k] = 1'b1;
      else if (ovr_clr) m_ovr[k] = 1'b0;
      if (commit) begin
        m_len[k][m_wr[k]] = (int'(lnctrl_len) > DEPTH) ? DEPTH : int'(lnctrl_len);
        m_wr[k] = (m_wr[k] + 1) % nb[k];
      end
      if (rel) m_rd[k] = (m_rd[k] + 1) % nb[k];
      m_occ[k] = m_occ[k] + int'(commit) - int'(rel);
    end
  endtask

  task automatic check_inst(input int k, input int d, input int rdy, input int l,
                            input int go, input int ov, input int oc);
    check($sformatf("occ[%0d]", k), oc, m_occ[k]);
    check($sformatf("bsm_rdy[%0d]", k), rdy, int'(m_occ[k] != 0));
    check($sformatf("rx_flow_go[%0d]", k), go, int'(m_occ[k] != nb[k]));
    check($sformatf("bsm_len[%0d]", k), l, m_len[k][m_rd[k]]);
    check($sformatf("overrun[%0d]", k), ov, int'(m_ovr[k]));
    if (m_dknown[k]) check($sformatf("bsm_dout[%0d]", k), d, int'(m_dout[k]));
  endtask

  task automatic check_all();
    check_inst(0, int'(dout4), int'(rdy4), int'(len4), int'(go4), int'(ovr4), int'(occ4));
    check_inst(1, int'(dout3), int'(rdy3), int'(len3), int'(go3), int'(ovr3), int'(occ3));
  endtask

  task automatic idle();
    lnctrl_cs = 0; lnctrl_we = 0; lnctrl_addr = '0; lnctrl_din = '0;
    lnctrl_wr_endp = 0; lnctrl_len = '0; lnctrl_crc_ok = 1;
    bsm_cs = 0; bsm_addr = '0; bsm_read_endp = 0; ovr_clr = 0;
  endtask

  // Model advances on the same edge as the DUTs; outputs compared 1 time unit later.
  task automatic tick();
    @(posedge clk_6M);
    model_step();
    #1;
    check_all();
    idle();
  endtask

  task automatic wr(input int a, input int d);
    lnctrl_cs = 1; lnctrl_we = 1; lnctrl_addr = AW'(a); lnctrl_din = DW'(d); tick();
  endtask

  task automatic endp(input int l, input bit crc);
    lnctrl_wr_endp = 1; lnctrl_len = (AW+1)'(l); lnctrl_crc_ok = crc; tick();
  endtask

  task automatic rd(input int a);
    bsm_cs = 1; bsm_addr = AW'(a); tick();
  endtask

  task automatic rel();
    bsm_read_endp = 1; tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) rel();
  endtask

  task automatic rand_cycle();
    lnctrl_cs      = ($urandom_range(0, 3) != 0);
    lnctrl_we      = 1'($urandom_range(0, 1));
    lnctrl_addr    = AW'($urandom);
    lnctrl_din     = DW'($urandom);
    lnctrl_wr_endp = ($urandom_range(0, 7) == 0);
    lnctrl_len     = (AW+1)'($urandom);
    lnctrl_crc_ok  = ($urandom_range(0, 3) != 0);
    bsm_cs         = 1'($urandom_range(0, 1));
    bsm_addr       = AW'($urandom);
    bsm_read_endp  = ($urandom_range(0, 6) == 0);
    ovr_clr        = ($urandom_range(0, 15) == 0);
    tick();
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_all();
    rstz = 1'b1;

    // Four words into bank 0, commit len 4, read back address 2.
    for (int i = 0; i < 4; i++) wr(i, 16'hA0 + i);
    endp(4, 1'b1);
    rd(2);
    tick();

    // Commit and release together with occ=1.
    wr(0, 16'h5511);
    lnctrl_wr_endp = 1; lnctrl_len = 5'd7; bsm_read_endp = 1; tick();
    rd(0);

    // Fill every bank, then attempt a write and an extra end-of-payload.
    for (int i = 0; i < 4; i++) endp(i + 1, 1'b1);
    wr(3, 16'hDEAD);
    endp(2, 1'b1);
    ovr_clr = 1; tick();
    wr(3, 16'hBEEF);
    ovr_clr = 1; lnctrl_wr_endp = 1; tick();
    ovr_clr = 1; tick();

    // Length clamp at and above 2^AW.
    drain();
    endp(31, 1'b1);
    endp(16, 1'b1);
    endp(17, 1'b1);
    rel(); rel(); rel();

    // CRC failure on an empty buffer.
    drain();
    endp(9, 1'b0);
    drain();

    // Nine commit/release rounds walk the pointers round both rings.
    for (int i = 0; i < 9; i++) begin
      wr(0, 16'h1000 + i * 16);
      wr(1, 16'h2000 + i * 16);
      endp(2, 1'b1);
      rd(1);
      rd(0);
      rel();
    end

    for (int i = 0; i < 600; i++) rand_cycle();

    // Reset with two committed banks.
    drain();
    endp(3, 1'b1);
    endp(5, 1'b1);
    rstz = 1'b0;
    #2;
    model_reset();
    check_all();
    #3;
    rstz = 1'b1;
    for (int i = 0; i < 100; i++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
